// File: rtl/fc2_ctrl.sv
// FC2 layer sequencer: clears and feeds the MAC array, writes results, then drains N_OUT words downstream.
// Optional protocol error detection is built when FC2_CTRL_BUSY_ERR_EN is defined.
module fc2_ctrl #(
  parameter int N_IN   = 120,
  parameter int N_OUT  = 84,
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       drain_ready,
  output logic       busy,
  output logic       done,
  output logic       f6_ren,
  output logic [6:0] f6_raddr,
  output logic [6:0] w_addr,
  output logic       mac_clr,
  output logic       mac_en,
  output logic       f7_wr_en,
  output logic [6:0] f7_raddr,
  output logic       out_valid,
  output logic       out_last,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CLR      = 4'd1,
    ACC      = 4'd2,
    FLUSH    = 4'd3,
    WR       = 4'd4,
    WAIT_RDY = 4'd5,
    DRAIN    = 4'd6,
    TAIL     = 4'd7,
    DONE     = 4'd8
  } state_t;

  localparam int CW = $clog2(RD_LAT + 2);

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic                iss_r;
  logic [RD_LAT-1:0]   mac_dly_r;
  logic [RD_LAT-1:0]   val_dly_r;
  logic [RD_LAT-1:0]   last_dly_r;
  logic [RD_LAT:0]     mac_pipe_s;
  logic [RD_LAT:0]     val_pipe_s;
  logic [RD_LAT:0]     last_pipe_s;
  logic                last_src_s;

  // The weight ROM is addressed in lockstep with the input buffer.
  assign w_addr      = f6_raddr;
  assign last_src_s  = iss_r && (f7_raddr == 7'(N_OUT - 1));
  assign mac_pipe_s  = {mac_dly_r, f6_ren};
  assign val_pipe_s  = {val_dly_r, iss_r};
  assign last_pipe_s = {last_dly_r, last_src_s};
  assign mac_en      = mac_dly_r[RD_LAT-1];
  assign out_valid   = val_dly_r[RD_LAT-1];
  assign out_last    = last_dly_r[RD_LAT-1];

  // Sequencer state, counters and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      iss_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      f6_ren   <= 1'b0;
      f6_raddr <= 7'd0;
      mac_clr  <= 1'b0;
      f7_wr_en <= 1'b0;
      f7_raddr <= 7'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= CLR;
            mac_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        CLR: begin
          state_r  <= ACC;
          mac_clr  <= 1'b0;
          f6_ren   <= 1'b1;
          f6_raddr <= 7'd0;
        end
        ACC: begin
          if (f6_raddr == 7'(N_IN - 1)) begin
            state_r <= FLUSH;
            f6_ren  <= 1'b0;
            cnt_r   <= '0;
          end else begin
            f6_raddr <= f6_raddr + 7'd1;
          end
        end
        FLUSH: begin
          // Wait for the last in-flight mac_en to land and register.
          if (cnt_r == CW'(RD_LAT)) begin
            state_r  <= WR;
            f7_wr_en <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        WR: begin
          state_r  <= WAIT_RDY;
          f7_wr_en <= 1'b0;
        end
        WAIT_RDY: begin
          if (drain_ready) begin
            state_r  <= DRAIN;
            iss_r    <= 1'b1;
            f7_raddr <= 7'd0;
          end
        end
        DRAIN: begin
          if (f7_raddr == 7'(N_OUT - 1)) begin
            state_r <= TAIL;
            iss_r   <= 1'b0;
            cnt_r   <= '0;
          end else begin
            f7_raddr <= f7_raddr + 7'd1;
          end
        end
        TAIL: begin
          if (cnt_r == CW'(RD_LAT - 1)) begin
            state_r <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          f6_ren   <= 1'b0;
          mac_clr  <= 1'b0;
          f7_wr_en <= 1'b0;
          iss_r    <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency delay lines for accumulate enable and drain valid/last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_dly_r  <= '0;
      val_dly_r  <= '0;
      last_dly_r <= '0;
    end else begin
      mac_dly_r  <= mac_pipe_s[RD_LAT-1:0];
      val_dly_r  <= val_pipe_s[RD_LAT-1:0];
      last_dly_r <= last_pipe_s[RD_LAT-1:0];
    end
  end

`ifdef FC2_CTRL_BUSY_ERR_EN
  // Sticky flag: start while busy, or downstream withdrawing readiness mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((start && busy) || (state_r == DRAIN && !drain_ready)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fc2_ctrl.sv
// Directed bench for fc2_ctrl at default parameters; k counts rising edges after the edge that samples start.
module tb_fc2_ctrl;

`ifdef FC2_CTRL_BUSY_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       drain_ready = 1'b1;
  logic       busy, done, f6_ren, mac_clr, mac_en, f7_wr_en, out_valid, out_last, err;
  logic [6:0] f6_raddr, w_addr, f7_raddr;

  int n_cmp = 0;
  int n_err = 0;

  int n_clr, clr_k, n_mac, n_wr, n_val, n_last, last_idx, n_done, done_at;
  int addr_err, lag_err, idx_err, raddr_mid;

  fc2_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .drain_ready(drain_ready),
    .busy(busy), .done(done), .f6_ren(f6_ren), .f6_raddr(f6_raddr),
    .w_addr(w_addr), .mac_clr(mac_clr), .mac_en(mac_en), .f7_wr_en(f7_wr_en),
    .f7_raddr(f7_raddr), .out_valid(out_valid), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] all_outs();
    return {busy, done, f6_ren, f6_raddr, w_addr, mac_clr, mac_en, f7_wr_en,
            f7_raddr, out_valid, out_last, err};
  endfunction

  // One inference; rise_k/extra_k/drop_k/abort_k = -1 disables that event.
  task automatic run(input int rise_k, input int extra_k, input bit start_on_done,
                     input int drop_k, input int abort_k, input int post);
    int  exp_f6 = 0;
    logic ren_h1 = 1'b0, ren_h2 = 1'b0;
    int  rad_h1 = 0, rad_h2 = 0;
    n_clr = 0; clr_k = -1; n_mac = 0; n_wr = 0; n_val = 0; n_last = 0;
    last_idx = -1; n_done = 0; done_at = -1; addr_err = 0; lag_err = 0;
    idx_err = 0; raddr_mid = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        chk("abort_outs_zero", 32'(all_outs()), 32'd0);
        return;
      end
      if (mac_clr) begin n_clr++; clr_k = k; end
      if (f6_ren) begin
        if (f6_raddr != 7'(exp_f6) || w_addr != f6_raddr) addr_err++;
        exp_f6++;
      end
      if (mac_en != ren_h2) lag_err++;
      if (mac_en) n_mac++;
      if (f7_wr_en) n_wr++;
      if (out_valid) begin
        if (rad_h2 != n_val || out_last != (n_val == 83)) idx_err++;
        if (out_last) begin n_last++; last_idx = n_val; end
        n_val++;
      end else if (out_last) begin
        idx_err++;
      end
      if (k == 150) raddr_mid = int'(f7_raddr);
      ren_h2 = ren_h1; ren_h1 = f6_ren;
      rad_h2 = rad_h1; rad_h1 = int'(f7_raddr);
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = k;
        if (start_on_done) start = 1'b1;
      end
      if (k == extra_k) start = 1'b1;
      if (k == rise_k) drain_ready = 1'b1;
      if (k == drop_k) drain_ready = 1'b0;
      if (done_at >= 0 && k >= done_at + post) break;
    end
    start = 1'b0;
  endtask

  task automatic verify(input string tag, input int exp_done, input logic exp_err);
    chk({tag, "_done_at"}, 32'(done_at), 32'(exp_done));
    chk({tag, "_n_done"}, 32'(n_done), 32'd1);
    chk({tag, "_clr"}, 32'(n_clr * 1000 + clr_k), 32'd1000);
    chk({tag, "_addr"}, 32'(addr_err), 32'd0);
    chk({tag, "_mac_lag"}, 32'(lag_err), 32'd0);
    chk({tag, "_n_mac"}, 32'(n_mac), 32'd120);
    chk({tag, "_n_wr"}, 32'(n_wr), 32'd1);
    chk({tag, "_n_valid"}, 32'(n_val), 32'd84);
    chk({tag, "_last"}, 32'(n_last * 1000 + last_idx), 32'd1083);
    chk({tag, "_idx"}, 32'(idx_err), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    int quiet;
    // Reset state
    #12;
    chk("reset_outs_zero", 32'(all_outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", 32'(all_outs()), 32'd0);

    // Nominal inference
    run(-1, -1, 1'b0, -1, -1, 4);
    verify("nominal", 212, 1'b0);
    chk("nominal_idle", 32'(busy), 32'd0);

    // Downstream not ready for 50 cycles after WR
    drain_ready = 1'b0;
    run(175, -1, 1'b0, -1, -1, 4);
    verify("wait50", 262, 1'b0);
    chk("wait50_raddr_hold", 32'(raddr_mid), 32'd83);

    // Start while busy and on the done cycle
    run(-1, 10, 1'b1, -1, -1, 4);
    verify("restart", 212, ERR_ON);
    chk("restart_no_busy", 32'(busy), 32'd0);

    // Reset mid-ACC
    run(-1, -1, 1'b0, -1, 61, 4);
    quiet = 0;
    repeat (3) begin
      @(posedge clk); #1;
      quiet += int'(mac_en) + int'(done) + int'(out_valid) + int'(busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      quiet += int'(mac_en) + int'(done) + int'(out_valid) + int'(busy);
    end
    chk("abort_quiet", 32'(quiet), 32'd0);
    chk("abort_err_clr", 32'(err), 32'd0);
    run(-1, -1, 1'b0, -1, -1, 4);
    verify("fresh", 212, 1'b0);

    // Back-to-back
    run(-1, -1, 1'b0, -1, -1, 1);
    verify("b2b_1", 212, 1'b0);
    run(-1, -1, 1'b0, -1, -1, 4);
    verify("b2b_2", 212, 1'b0);

    // drain_ready dropped at DRAIN index 40
    run(-1, -1, 1'b0, 166, -1, 4);
    verify("drop", 212, ERR_ON);
    drain_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
